// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder_ctrl_if
//  Purpose  : Operand/result handshake bundle for the nibble-serial adder.
//  Revision : 1.0  initial release
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int c_W = 4 * NIBBLES;

  logic           start;
  logic           op;
  logic [c_W-1:0] a;
  logic [c_W-1:0] b;
  logic           cin;
  logic           busy;
  logic           done;
  logic [c_W-1:0] sum;
  logic           cout;

  // Host side: issues operations and reads back the result.
  modport master (
    output start, op, a, b, cin,
    input  busy, done, sum, cout
  );

  // Adder side: consumes operations and presents the registered result.
  modport slave (
    input  start, op, a, b, cin,
    output busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder_ctrl
//  Purpose  : Wide add/subtract built from one shared 4-bit ripple slice.
//  Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  wire                          clock,
  input  wire                          resetn,
  nibble_serial_adder_ctrl_if.slave    bus
);
  localparam int c_W     = 4 * NIBBLES;
  localparam int c_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_W-1:0]       r_a;
  logic [c_W-1:0]       r_b;
  logic [c_W-1:0]       r_sum;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_carry;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_cout;

  logic [3:0]           w_a_nib;
  logic [3:0]           w_b_nib;
  logic [3:0]           w_slice_sum;
  logic [4:0]           w_c;

  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];
  assign w_c[0]  = r_carry;

  // The shared slice: four chained full adders, purely combinational.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      assign w_slice_sum[gi] = w_a_nib[gi] ^ w_b_nib[gi] ^ w_c[gi];
      assign w_c[gi+1]       = (w_a_nib[gi] & w_b_nib[gi]) |
                               (w_c[gi] & (w_a_nib[gi] ^ w_b_nib[gi]));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            // Subtract is A + ~B + 1, so the inversion and the +1 happen here.
            r_a     <= bus.a;
            r_b     <= bus.op ? ~bus.b : bus.b;
            r_carry <= bus.op ? 1'b1 : bus.cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
          r_carry <= w_c[4];
          r_idx   <= r_idx + c_IDX_W'(1);
          if (r_idx == c_LAST) begin
            r_cout  <= w_c[4];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_serial_adder_ctrl
//  Purpose  : Self-checking bench: vector table, scoreboard, corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;
  localparam int NIB = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  nibble_serial_adder_ctrl_if #(.NIBBLES(NIB)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", bus.sum, e.sum);
        check("cout", bus.cout, e.cout);
      end
    end
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic op, input logic cin);
    logic [16:0] r;
    exp_t e;
    if (op) r = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else    r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    e.sum  = r[15:0];
    e.cout = r[16];
    return e;
  endfunction

  // One full operation with cycle-accurate busy/done checks; inputs are
  // scrambled after acceptance to prove they were latched.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic op, input logic cin,
                        input logic [15:0] es, input logic ec);
    exp_t e;
    e.sum = es; e.cout = ec;
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.op = op; bus.cin = cin;
    sb.push_back(e);
    tick();
    bus.start = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.op = 1'($urandom); bus.cin = 1'($urandom);
    for (int k = 1; k <= NIB; k++) begin
      check("busy_run", bus.busy, 1'b1);
      check("done_run", bus.done, 1'b0);
      tick();
    end
    check("done_pulse", bus.done, 1'b1);
    check("busy_done", bus.busy, 1'b0);
    tick();
    check("done_clear", bus.done, 1'b0);
    check("hold_sum", bus.sum, es);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1});
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hABCD, 16'h1234, 1'b0, 1'b1, 16'hBE02, 1'b0});
    vecs.push_back('{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0});
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      exp_t e;
      v.a = 16'($urandom); v.b = 16'($urandom);
      v.op = 1'($urandom); v.cin = 1'($urandom);
      e = model(v.a, v.b, v.op, v.cin);
      v.exp_sum = e.sum; v.exp_cout = e.cout;
      vecs.push_back(v);
    end

    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_sum", bus.sum, 16'h0000);
      check("rst_cout", bus.cout, 1'b0);
      tick();
    end

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout);

    // Start held high while busy: only re-accepted once back in IDLE.
    begin
      exp_t e;
      e.sum = 16'h3333; e.cout = 1'b0;
      bus.start = 1'b1; bus.op = 1'b0; bus.cin = 1'b0;
      bus.a = 16'h1111; bus.b = 16'h2222;
      sb.push_back(e);
      tick();
      bus.a = 16'hAAAA; bus.b = 16'h5555;
      for (int c = 1; c <= 11; c++) begin
        check("hold_done", bus.done, (c == 5 || c == 11));
        check("hold_busy", bus.busy, ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
        if (c == 6) begin
          e.sum = 16'hFFFF; e.cout = 1'b0;
          sb.push_back(e);
        end
        tick();
        if (c == 6) bus.start = 1'b0;
      end
    end

    // Reset in the middle of an operation discards it without a done pulse.
    bus.start = 1'b1; bus.op = 1'b0; bus.cin = 1'b0;
    bus.a = 16'h1234; bus.b = 16'h1111;
    tick();
    bus.start = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_sum", bus.sum, 16'h0000);
    check("mid_rst_cout", bus.cout, 1'b0);
    for (int k = 0; k < 6; k++) begin
      check("mid_rst_nodone", bus.done, 1'b0);
      tick();
    end
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);

    tick(); tick();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
